sd_block_buffer: RTL
====================

SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, FIFO depth 2^DEPTH_LOG2 32-bit words; legal values are 7 to 10 only.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all logic SHALL be in this domain.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port buffer_write_enable, input, 1, a one-cycle write strobe from the ADC serial stage.
REQ-005 The block SHALL have port adc_buffer_data, input, 32, the sample word, valid with buffer_write_enable.
REQ-006 The block SHALL have port buffer_full, output, 1, high when the FIFO holds 2^DEPTH_LOG2 words.
REQ-007 The block SHALL have port block_available, output, 1, high when the FIFO holds at least 128 words.
REQ-008 The block SHALL have port block_start, input, 1, the SD writer's request for one 512-byte block.
REQ-009 The block SHALL have port byte_data, output, 8, the outgoing block byte.
REQ-010 The block SHALL have port byte_valid, output, 1, high when byte_data is valid.
REQ-011 The block SHALL have port byte_ready, input, 1, high when the SD writer accepts byte_data.
REQ-012 The block SHALL have port block_done, output, 1, a one-cycle pulse after the last byte of a block.
REQ-013 The block SHALL have port word_count, output, DEPTH_LOG2+1, the current FIFO occupancy.
REQ-014 The block SHALL have port overflow, output, 1, a sticky flag set by a write attempted while full.

Function
REQ-015 A write SHALL be accepted on a clock edge with buffer_write_enable=1 and buffer_full=0, storing the word at the write pointer; the pointer SHALL wrap modulo 2^DEPTH_LOG2.
REQ-016 A write with buffer_full=1 SHALL be dropped, SHALL leave pointers and word_count unchanged, and SHALL set overflow, which clears only on reset.
REQ-017 The state machine SHALL have states IDLE, LOAD, SEND, CRC and DONE.
REQ-018 In IDLE, block_start=1 with block_available=1 SHALL go to LOAD; block_start with block_available=0 SHALL be ignored.
REQ-019 LOAD SHALL pop one word (read pointer+1, word_count-1) into a 32-bit shift register, then go to SEND with byte index 0.
REQ-020 In SEND, byte_valid=1 and byte_data SHALL be shift-register bits [31:24] first, then [23:16], [15:8], [7:0] (MSB first).
REQ-021 byte_data SHALL hold stable until byte_valid and byte_ready are both 1 in the same cycle; the byte then advances.
REQ-022 After each fourth byte, SEND SHALL pop the next word in the same cycle, with no bubble, unless 512 bytes have been sent.
REQ-023 After byte 512, the block SHALL go to CRC if SD_BLOCK_CRC_EN is defined, else to DONE.
REQ-024 DONE SHALL pulse block_done for one cycle with byte_valid=0, then return to IDLE.
REQ-025 The first byte_valid SHALL be asserted two cycles after the block_start edge.
REQ-026 A simultaneous accepted write and pop SHALL leave word_count unchanged; write-side rules SHALL apply regardless of state.
REQ-027 buffer_full SHALL equal (word_count == 2^DEPTH_LOG2) and block_available SHALL equal (word_count >= 128), both combinational from registered word_count.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state IDLE, pointers 0, word_count 0, buffer_full 0, block_available 0, byte_valid 0, byte_data 0, block_done 0, overflow 0 and CRC register 0.
REQ-029 Reset mid-block SHALL abandon the block with no block_done; FIFO memory contents need not be cleared.

Configuration
REQ-030 With SD_BLOCK_CRC_EN defined, the block SHALL compute CRC-16-CCITT (polynomial 0x1021, initial value 0x0000, no reflection) over the 512 accepted bytes and send it in state CRC as 2 bytes, MSB first, under the same handshake, for 514 bytes per block.
REQ-031 Without SD_BLOCK_CRC_EN, the block SHALL contain no CRC logic, SHALL send 512 bytes per block, and SHALL never enter the CRC state.

Verification
REQ-032 The bench SHALL write 128 words 0x00000000..0x0000007F -> block_available=1 after the 128th write, word_count=128.
REQ-033 The bench SHALL then pulse block_start with byte_ready held 1 -> byte_valid 2 cycles later, bytes 00 00 00 00 00 00 00 01 ..., block_done at byte 512 (or 514 with CRC), word_count=0.
REQ-034 With DEPTH_LOG2=8, the bench SHALL write 257 words -> buffer_full=1 after 256 writes, the 257th is dropped, overflow=1, word_count=256.
REQ-035 In SEND, the bench SHALL drive byte_ready=0 for 5 cycles -> byte_data and byte_valid hold, no byte is lost or duplicated.
REQ-036 With SD_BLOCK_CRC_EN, the bench SHALL send 128 words of 0xFFFFFFFF -> the 2 CRC bytes equal 0x7FA1.
REQ-037 The bench SHALL assert reset_n=0 at byte 100 of a block -> byte_valid=0 at once, word_count=0, state IDLE, no block_done.

Source files
------------

// File: rtl/sd_block_buffer.sv
// sd_block_buffer
// Buffers 32-bit ADC sample words and hands them to an SD card writer as
// 512-byte blocks (128 words, each sent MSB byte first) under a valid/ready
// byte handshake.
// DEPTH_LOG2 sets the FIFO depth to 2^DEPTH_LOG2 words. The legal range is
// 7 to 10, so that one whole block always fits in the FIFO.
// Optional feature: define SD_BLOCK_CRC_EN to append a CRC-16-CCITT
// (poly 0x1021, init 0x0000) over the 512 data bytes. The CRC is sent as
// two extra bytes, MSB first, giving 514 bytes per block.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for block_start while at least 128 words are buffered
// LOAD  | pop the first word of the block into the shift register
// SEND  | present data bytes, pop the next word after every fourth byte
// CRC   | present the two CRC bytes (only with SD_BLOCK_CRC_EN)
// DONE  | one-cycle block_done pulse, then back to IDLE

module sd_block_buffer #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  buffer_write_enable,
   input  logic [31:0]           adc_buffer_data,
   output logic                  buffer_full,
   output logic                  block_available,
   input  logic                  block_start,
   output logic [7:0]            byte_data,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic                  block_done,
   output logic [DEPTH_LOG2:0]   word_count,
   output logic                  overflow
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] BLK_CNT  = (DEPTH_LOG2+1)'(128);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [9:0]        LAST_BYTE = 10'd511;

   typedef enum logic [2:0] {IDLE, LOAD, SEND, CRC, DONE} state_t;

   logic [31:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    overflow_q;
   state_t                  state_q;
   logic [23:0]             shreg_q;
   logic [7:0]              byte_data_q;
   logic                    byte_valid_q;
   logic                    block_done_q;
   logic [9:0]              byte_cnt_q;
   logic [31:0]             rd_word;
   logic                    wr_acc;
   logic                    accept;
   logic                    pop;
`ifdef SD_BLOCK_CRC_EN
   logic [15:0]             crc_q;
   logic [15:0]             crc_next;
   logic                    crc_sel_q;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
      return c;
   endfunction

   assign crc_next = crc16_byte(crc_q, byte_data_q);
`endif

   assign buffer_full     = (count_q == FULL_CNT);
   assign block_available = (count_q >= BLK_CNT);
   assign word_count      = count_q;
   assign overflow        = overflow_q;
   assign byte_data       = byte_data_q;
   assign byte_valid      = byte_valid_q;
   assign block_done      = block_done_q;
   assign rd_word         = mem[rd_ptr_q];

   // FIFO control: write acceptance, pops requested by the block sequencer, next pointers/count
   always_comb begin
      wr_acc   = buffer_write_enable & ~buffer_full;
      accept   = byte_valid_q & byte_ready;
      pop      = (state_q == LOAD) |
                 ((state_q == SEND) & accept & (byte_cnt_q[1:0] == 2'd3) & (byte_cnt_q != LAST_BYTE));
      wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Sample storage; contents are deliberately left untouched by reset
   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= adc_buffer_data;
      end
   end

   // Pointer, occupancy and sticky overflow registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (buffer_write_enable && buffer_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Block sequencer with registered byte/handshake outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         byte_data_q  <= '0;
         byte_valid_q <= 1'b0;
         block_done_q <= 1'b0;
         byte_cnt_q   <= '0;
`ifdef SD_BLOCK_CRC_EN
         crc_q        <= '0;
         crc_sel_q    <= 1'b0;
`endif
      end else begin
         block_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (block_start && block_available) begin
                  state_q    <= LOAD;
                  byte_cnt_q <= '0;
`ifdef SD_BLOCK_CRC_EN
                  crc_q      <= '0;
                  crc_sel_q  <= 1'b0;
`endif
               end
            end
            LOAD: begin
               shreg_q      <= rd_word[23:0];
               byte_data_q  <= rd_word[31:24];
               byte_valid_q <= 1'b1;
               state_q      <= SEND;
            end
            SEND: begin
               if (accept) begin
                  byte_cnt_q <= byte_cnt_q + 10'd1;
`ifdef SD_BLOCK_CRC_EN
                  crc_q      <= crc_next;
`endif
                  if (byte_cnt_q == LAST_BYTE) begin
`ifdef SD_BLOCK_CRC_EN
                     state_q      <= CRC;
                     byte_data_q  <= crc_next[15:8];
                     crc_sel_q    <= 1'b0;
`else
                     state_q      <= DONE;
                     byte_valid_q <= 1'b0;
                     block_done_q <= 1'b1;
`endif
                  end else if (byte_cnt_q[1:0] == 2'd3) begin
                     // next word is popped in this same cycle so there is no bubble
                     shreg_q     <= rd_word[23:0];
                     byte_data_q <= rd_word[31:24];
                  end else begin
                     byte_data_q <= shreg_q[23:16];
                     shreg_q     <= {shreg_q[15:0], 8'h00};
                  end
               end
            end
`ifdef SD_BLOCK_CRC_EN
            CRC: begin
               if (accept) begin
                  if (!crc_sel_q) begin
                     byte_data_q <= crc_q[7:0];
                     crc_sel_q   <= 1'b1;
                  end else begin
                     state_q      <= DONE;
                     byte_valid_q <= 1'b0;
                     block_done_q <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q      <= IDLE;
               byte_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
